// File: rtl/shift_l_sequencer_if.sv
// Handshake and data bundle between a sequencer requester and shift_l_sequencer.
// The master drives load/shift controls; the slave returns register state and strobes.
interface shift_l_sequencer_if;
   logic       start;
   logic [3:0] din;
   logic [2:0] n_shift;
   logic       sin;
   logic [3:0] q;
   logic       sout;
   logic       sl;
   logic       busy;
   logic       done;

   modport master (
      output start, din, n_shift, sin,
      input  q, sout, sl, busy, done
   );

   modport slave (
      input  start, din, n_shift, sin,
      output q, sout, sl, busy, done
   );
endinterface

// File: rtl/shift_l_sequencer.sv
// Loads a 4-bit value and left-shifts it n_shift times, one shift every DIV clocks,
// emitting a one-cycle sl strobe per shift and a done pulse at the end of the sequence.
module shift_l_sequencer #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   shift_l_sequencer_if.slave bus
);

   localparam logic [7:0] PRE_LAST = 8'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] q_q, q_d;
   logic       sout_q, sout_d;
   logic       sl_q, sl_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] pre_q, pre_d;
   logic [2:0] rem_q, rem_d;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      sout_d  = sout_q;
      sl_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pre_d   = pre_q;
      rem_d   = rem_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               q_d    = bus.din;
               rem_d  = bus.n_shift;
               pre_d  = 8'd0;
               busy_d = 1'b1;
               if (bus.n_shift != 3'd0) begin
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end

         S_SHIFT: begin
            // The prescaler wraps on the shift edge, so shift k lands exactly k*DIV edges after load.
            if (pre_q == PRE_LAST) begin
               q_d    = {q_q[2:0], bus.sin};
               sout_d = q_q[3];
               sl_d   = 1'b1;
               pre_d  = 8'd0;
               rem_d  = 3'(rem_q - 3'd1);
               if (rem_q == 3'd1) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end else begin
               pre_d = 8'(pre_q + 8'd1);
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         q_q     <= 4'b0000;
         sout_q  <= 1'b0;
         sl_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pre_q   <= 8'd0;
         rem_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         sout_q  <= sout_d;
         sl_q    <= sl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pre_q   <= pre_d;
         rem_q   <= rem_d;
      end
   end

   assign bus.q    = q_q;
   assign bus.sout = sout_q;
   assign bus.sl   = sl_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_shift_l_sequencer.sv
// Drives a DIV=4 and a DIV=1 sequencer with shared stimulus and compares both against
// a timeline model: shift k of a sequence loaded at edge T happens at edge T+k*DIV.
module tb_shift_l_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] din = 4'd0;
   logic [2:0] n_shift = 3'd0;
   logic       sin = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   shift_l_sequencer_if bus4 ();
   shift_l_sequencer_if bus1 ();

   assign bus4.start   = start;
   assign bus4.din     = din;
   assign bus4.n_shift = n_shift;
   assign bus4.sin     = sin;
   assign bus1.start   = start;
   assign bus1.din     = din;
   assign bus1.n_shift = n_shift;
   assign bus1.sin     = sin;

   shift_l_sequencer #(.DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   shift_l_sequencer #(.DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int         divs [2] = '{4, 1};
   bit         m_act [2];
   int         m_end [2];
   int         m_t0 [2];
   logic [3:0] m_q [2];
   logic       m_sout [2];
   logic       m_sl [2];
   logic       m_busy [2];
   logic       m_done [2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_end[i] = 0; m_t0[i] = 0;
         m_q[i] = 4'b0000; m_sout[i] = 1'b0; m_sl[i] = 1'b0;
         m_busy[i] = 1'b0; m_done[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         m_sl[i] = 1'b0;
         if (!m_act[i]) begin
            m_done[i] = 1'b0;
            if (start) begin
               m_act[i]  = 1'b1;
               m_t0[i]   = cyc;
               m_end[i]  = cyc + int'(n_shift) * divs[i];
               m_q[i]    = din;
               m_busy[i] = 1'b1;
               m_done[i] = (n_shift == 3'd0);
            end
         end else if (cyc == m_end[i] + 1) begin
            m_act[i]  = 1'b0;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
         end else if (cyc > m_t0[i] && cyc <= m_end[i] && ((cyc - m_t0[i]) % divs[i]) == 0) begin
            m_sout[i] = m_q[i][3];
            m_q[i]    = ((m_q[i] << 1) | {3'b000, sin}) & 4'hF;
            m_sl[i]   = 1'b1;
            if (cyc == m_end[i]) m_done[i] = 1'b1;
         end
      end
   endtask

   task automatic check_one(input string nm, input int i, input logic [3:0] q,
                            input logic sout, input logic sl, input logic busy, input logic done);
      chk({nm, "_q"},    {4'd0, q},    {4'd0, m_q[i]});
      chk({nm, "_sout"}, {7'd0, sout}, {7'd0, m_sout[i]});
      chk({nm, "_sl"},   {7'd0, sl},   {7'd0, m_sl[i]});
      chk({nm, "_busy"}, {7'd0, busy}, {7'd0, m_busy[i]});
      chk({nm, "_done"}, {7'd0, done}, {7'd0, m_done[i]});
   endtask

   task automatic check_all();
      check_one("div4", 0, bus4.q, bus4.sout, bus4.sl, bus4.busy, bus4.done);
      check_one("div1", 1, bus1.q, bus1.sout, bus1.sl, bus1.busy, bus1.done);
   endtask

   // One clock: inputs set at the falling edge, optional async reset pulse mid-low-phase,
   // then model and DUT outputs compared 1 time unit after the rising edge.
   task automatic step(input logic st, input logic [3:0] d, input logic [2:0] n,
                       input logic s, input bit do_rst);
      @(negedge clk);
      start = st; din = d; n_shift = n; sin = s;
      if (do_rst) begin
         #1 rst_n = 1'b0;
         #1 model_reset();
         check_all();
         #1 rst_n = 1'b1;
      end
      @(posedge clk);
      cyc++;
      model_edge();
      #1 check_all();
   endtask

   task automatic idle_steps(input int k, input logic s);
      for (int j = 0; j < k; j++) step(1'b0, 4'd0, 3'd0, s, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q",    {4'd0, bus4.q}, 8'd0);
      chk("rst_busy", {7'd0, bus4.busy}, 8'd0);
      chk("rst_done", {7'd0, bus4.done}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load 1011, two shifts of 0 at DIV=4.
      step(1'b1, 4'b1011, 3'd2, 1'b0, 1'b0);
      chk("r29_load_q", {4'd0, bus4.q}, 8'b1011);
      idle_steps(4, 1'b0);
      chk("r29_s1_q",   {4'd0, bus4.q}, 8'b0110);
      chk("r29_s1_out", {7'd0, bus4.sout}, 8'd1);
      chk("r29_s1_sl",  {7'd0, bus4.sl}, 8'd1);
      idle_steps(4, 1'b0);
      chk("r29_s2_q",   {4'd0, bus4.q}, 8'b1100);
      chk("r29_s2_sl",  {7'd0, bus4.sl}, 8'd1);
      chk("r29_s2_dn",  {7'd0, bus4.done}, 8'd1);
      idle_steps(1, 1'b0);
      chk("r29_busy",   {7'd0, bus4.busy}, 8'd0);
      idle_steps(2, 1'b0);

      // Six shifts filling with 1: register saturates to all ones.
      step(1'b1, 4'b0001, 3'd6, 1'b1, 1'b0);
      idle_steps(26, 1'b1);
      chk("r30_q", {4'd0, bus4.q}, 8'b1111);

      // Zero-length sequence.
      step(1'b1, 4'b1010, 3'd0, 1'b0, 1'b0);
      chk("r31_done", {7'd0, bus4.done}, 8'd1);
      chk("r31_q",    {4'd0, bus4.q}, 8'b1010);
      idle_steps(3, 1'b0);

      // start held high across a sequence with a different din.
      step(1'b1, 4'b1011, 3'd3, 1'b1, 1'b0);
      for (int j = 0; j < 30; j++) step(1'b1, 4'b0101, 3'd1, j[0], 1'b0);
      idle_steps(6, 1'b0);

      // Reset between the first and second shifts, then a normal sequence.
      step(1'b1, 4'b0011, 3'd3, 1'b1, 1'b0);
      idle_steps(5, 1'b1);
      step(1'b0, 4'd0, 3'd0, 1'b1, 1'b1);
      chk("r33_q", {4'd0, bus4.q}, 8'd0);
      idle_steps(12, 1'b1);
      step(1'b1, 4'b1001, 3'd2, 1'b0, 1'b0);
      idle_steps(12, 1'b1);

      // Reset while start=1, din=1111: start taken at the first edge after release.
      step(1'b1, 4'b1111, 3'd1, 1'b0, 1'b1);
      idle_steps(8, 1'b0);

      for (int j = 0; j < 600; j++) begin
         step(($urandom_range(0, 3) == 0), 4'($urandom), 3'($urandom),
              1'($urandom), ($urandom_range(0, 60) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
